// File: rtl/echo_request_deframer.sv
// echo_request_deframer: packs the 32-bit request word stream into one 144-bit framed message for the PipeIn enq port.
// Optional feature macro: DEFRAMER_ERRCNT_EN adds a saturating err_count of dropped (len>3) frames.
// Message layout: [143:128] method, [127:112] len, [111:80] arg0, [79:48] arg1, [47:16] arg2, [15:0] zero.
module echo_request_deframer #(
    parameter int MAX_ARGS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  beat_v,
    input  logic         beat_ena,
    output logic         beat_rdy,
    output logic [143:0] enq_v,
    output logic         enq_ena,
    input  logic         enq_rdy
`ifdef DEFRAMER_ERRCNT_EN
    ,
    output logic [15:0]  err_count
`endif
);
    typedef enum logic [1:0] {HDR, ARGS, DROP, FULL} state_t;

    state_t       state;
    logic [143:0] msg;
    logic [1:0]   idx;
    logic [15:0]  rem;
    logic         take;
    logic [15:0]  hdr_len;
    logic         last_arg;

    assign take     = beat_ena && beat_rdy;
    assign hdr_len  = beat_v[15:0];
    assign last_arg = {14'd0, idx} == msg[127:112] - 16'd1;
    assign beat_rdy = rst_n && state != FULL;
    assign enq_ena  = state == FULL && enq_rdy;
    assign enq_v    = msg;

    // Frame assembly FSM: header decode, argument fill, oversize discard, hold until enq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
            msg   <= '0;
            idx   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                HDR: if (take) begin
                    idx <= '0;
                    rem <= hdr_len;
                    if (hdr_len > 16'(MAX_ARGS)) begin
                        msg   <= '0;
                        state <= DROP;
                    end else begin
                        msg   <= {beat_v, 112'd0};
                        state <= hdr_len == 16'd0 ? FULL : ARGS;
                    end
                end
                ARGS: if (take) begin
                    msg[111 - 32 * int'(idx) -: 32] <= beat_v;
                    idx   <= idx + 2'd1;
                    state <= last_arg ? FULL : ARGS;
                end
                DROP: if (take) begin
                    rem   <= rem - 16'd1;
                    state <= rem == 16'd1 ? HDR : DROP;
                end
                FULL: if (enq_rdy) begin
                    msg   <= '0;
                    state <= HDR;
                end
                default: state <= HDR;
            endcase
        end
    end

`ifdef DEFRAMER_ERRCNT_EN
    // Count oversize headers on the HDR->DROP transition, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (state == HDR && take && hdr_len > 16'(MAX_ARGS) && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_echo_request_deframer.sv
// tb_echo_request_deframer: directed self-checking bench for echo_request_deframer.
module tb_echo_request_deframer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  beat_v = '0;
    logic         beat_ena = 1'b0;
    logic         beat_rdy;
    logic [143:0] enq_v;
    logic         enq_ena;
    logic         enq_rdy = 1'b1;
`ifdef DEFRAMER_ERRCNT_EN
    logic [15:0]  err_count;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [143:0] log_v[$];
    int           log_c[$];

    echo_request_deframer dut (
        .clk(clk),
        .rst_n(rst_n),
        .beat_v(beat_v),
        .beat_ena(beat_ena),
        .beat_rdy(beat_rdy),
        .enq_v(enq_v),
        .enq_ena(enq_ena),
        .enq_rdy(enq_rdy)
`ifdef DEFRAMER_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    // Log every enq transfer with its cycle number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (enq_ena) begin
            log_v.push_back(enq_v);
            log_c.push_back(cyc);
        end
    end

    task automatic send_beat(input logic [31:0] w);
        int n = 0;
        while (!beat_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (!beat_rdy) begin
            n_fail++;
            $display("FAIL beat_wait: beat_rdy=%0b required 1 within 50 cycles", beat_rdy);
        end
        beat_v   = w;
        beat_ena = 1'b1;
        @(posedge clk);
        #1;
        beat_ena = 1'b0;
        beat_v   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (beat_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %0b required 0", beat_rdy); end
        n_checks++;
        if (enq_ena !== 1'b0) begin n_fail++; $display("FAIL reset_ena: got %0b required 0", enq_ena); end
        n_checks++;
        if (enq_v !== 144'd0) begin n_fail++; $display("FAIL reset_buf: got %h required 0", enq_v); end
`ifdef DEFRAMER_ERRCNT_EN
        n_checks++;
        if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err: got %0d required 0", err_count); end
`endif
        idle(3);
        rst_n = 1'b1;
        idle(1);
        n_checks++;
        if (beat_rdy !== 1'b1) begin n_fail++; $display("FAIL release_rdy: got %0b required 1", beat_rdy); end
    endtask

    task automatic test_single_arg;
        int base = log_v.size();
        enq_rdy = 1'b1;
        send_beat(32'h0000_0001);
        send_beat(32'hDEAD_BEEF);
        n_checks++;
        if (enq_ena !== 1'b1) begin n_fail++; $display("FAIL single_ena: got %0b required 1", enq_ena); end
        n_checks++;
        if (enq_v !== {16'h0, 16'h1, 32'hDEAD_BEEF, 80'h0}) begin n_fail++; $display("FAIL single_v: got %h", enq_v); end
        idle(3);
        n_checks++;
        if (log_v.size() - base !== 1) begin n_fail++; $display("FAIL single_count: got %0d pulses required 1", log_v.size() - base); end
    endtask

    task automatic test_fields;
        send_beat(32'h0001_0001);
        send_beat(32'h1234_5678);
        n_checks++;
        if (enq_v[111:96] !== 16'h1234) begin n_fail++; $display("FAIL field_hi: got %h required 1234", enq_v[111:96]); end
        n_checks++;
        if (enq_v[95:80] !== 16'h5678) begin n_fail++; $display("FAIL field_lo: got %h required 5678", enq_v[95:80]); end
        n_checks++;
        if (enq_v[143:128] !== 16'h1) begin n_fail++; $display("FAIL field_method: got %h required 1", enq_v[143:128]); end
        idle(2);
    endtask

    task automatic test_hold;
        enq_rdy = 1'b0;
        send_beat(32'h0002_0000);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (beat_rdy !== 1'b0 || enq_ena !== 1'b0 || enq_v !== {16'h2, 16'h0, 112'h0}) begin
                n_fail++;
                $display("FAIL hold_%0d: rdy=%0b ena=%0b v=%h required rdy=0 ena=0 v=2_0000", i, beat_rdy, enq_ena, enq_v);
            end
            idle(1);
        end
        enq_rdy = 1'b1;
        #1;
        n_checks++;
        if (enq_ena !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %0b required 1", enq_ena); end
        idle(1);
        n_checks++;
        if (beat_rdy !== 1'b1 || enq_v !== 144'd0) begin n_fail++; $display("FAIL hold_after: rdy=%0b v=%h required rdy=1 v=0", beat_rdy, enq_v); end
    endtask

    task automatic test_drop;
        int base = log_v.size();
        send_beat(32'h0000_0005);
        for (int i = 0; i < 5; i++) send_beat(32'hBAD0_0000 + i);
        n_checks++;
        if (log_v.size() !== base) begin n_fail++; $display("FAIL drop_noenq: got %0d pulses required 0", log_v.size() - base); end
        send_beat(32'h0003_0001);
        send_beat(32'hCAFE_F00D);
        idle(2);
        n_checks++;
        if (log_v.size() - base !== 1) begin
            n_fail++;
            $display("FAIL drop_next_count: got %0d pulses required 1", log_v.size() - base);
        end else if (log_v[base] !== {16'h3, 16'h1, 32'hCAFE_F00D, 80'h0}) begin
            n_fail++;
            $display("FAIL drop_next_v: got %h", log_v[base]);
        end
`ifdef DEFRAMER_ERRCNT_EN
        n_checks++;
        if (err_count !== 16'd1) begin n_fail++; $display("FAIL drop_err: got %0d required 1", err_count); end
`endif
    endtask

    task automatic test_back_to_back;
        int base = log_v.size();
        send_beat(32'h0007_0003);
        send_beat(32'h1111_1111);
        send_beat(32'h2222_2222);
        send_beat(32'h3333_3333);
        send_beat(32'h0008_0003);
        send_beat(32'hAAAA_AAAA);
        send_beat(32'hBBBB_BBBB);
        send_beat(32'hCCCC_CCCC);
        send_beat(32'h0009_0001);
        send_beat(32'h4444_4444);
        idle(2);
        n_checks++;
        if (log_v.size() - base !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses required 3", log_v.size() - base);
        end else begin
            n_checks++;
            if (log_v[base] !== {16'h7, 16'h3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 16'h0}) begin
                n_fail++; $display("FAIL b2b_f1: got %h", log_v[base]);
            end
            n_checks++;
            if (log_v[base+1] !== {16'h8, 16'h3, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 16'h0}) begin
                n_fail++; $display("FAIL b2b_f2: got %h", log_v[base+1]);
            end
            n_checks++;
            if (log_v[base+2] !== {16'h9, 16'h1, 32'h4444_4444, 80'h0}) begin
                n_fail++; $display("FAIL b2b_noleak: got %h", log_v[base+2]);
            end
            n_checks++;
            if (log_c[base+1] - log_c[base] !== 5) begin
                n_fail++; $display("FAIL b2b_period: got %0d cycles required 5", log_c[base+1] - log_c[base]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        send_beat(32'h0004_0003);
        send_beat(32'h7777_7777);
        send_beat(32'h8888_8888);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (enq_ena !== 1'b0 || enq_v !== 144'd0 || beat_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: ena=%0b rdy=%0b v=%h required all 0", enq_ena, beat_rdy, enq_v);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        base = log_v.size();
        send_beat(32'h000A_0002);
        send_beat(32'h5555_5555);
        send_beat(32'h6666_6666);
        idle(2);
        n_checks++;
        if (log_v.size() - base !== 1) begin
            n_fail++;
            $display("FAIL midrst_next_count: got %0d pulses required 1", log_v.size() - base);
        end else if (log_v[base] !== {16'hA, 16'h2, 32'h5555_5555, 32'h6666_6666, 48'h0}) begin
            n_fail++;
            $display("FAIL midrst_next_v: got %h", log_v[base]);
        end
    endtask

    initial begin
        test_reset;
        test_single_arg;
        test_fields;
        test_hold;
        test_drop;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
